// File: rtl/regfile_load_arbiter.sv
// regfile_load_arbiter: UART frame loader and register-file write-port arbiter
//
// Assembles 5-byte UART frames (address byte, then 4 little-endian data bytes)
// into register-file writes and shares the single write port with pipeline
// writeback. Writeback wins by default; once a pending loader write has been
// blocked for MAX_WAIT cycles, stall_o freezes the pipeline for one cycle and
// the loader takes the port.
//
// Ports:
//   clk_o      in   clock, all state on posedge
//   rst        in   asynchronous active-high reset
//   rx_valid   in   UART byte available
//   rx_data    in   UART byte
//   rx_ready   out  byte consumed when rx_valid && rx_ready at posedge
//   wb_wr      in   writeback write request
//   wb_addr    in   writeback destination register
//   wb_data    in   writeback data
//   stall_o    out  freeze pipeline; writeback request is held and re-presented
//   rf_wr      out  register-file write enable
//   rf_waddr   out  register-file write address
//   rf_wdata   out  register-file write data
//   busy       out  loader frame in progress
//   load_count out  completed loader frames, wraps
//   err        out  sticky bad-address-byte flag, cleared only by rst
module regfile_load_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_o,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             wb_wr,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             stall_o,
    output logic             rf_wr,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             busy,
    output logic [CNT_W-1:0] load_count,
    output logic             err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, DATA, WRITE, DISCARD} state_t;

    state_t        state, state_nx;
    logic [1:0]    bcnt;
    logic [4:0]    addr;
    logic [31:0]   data;
    logic [WW-1:0] wait_cnt;
    logic          accept, at_max, grant, addr_ok;

    assign rx_ready = state != WRITE;
    assign accept   = rx_valid && rx_ready;
    assign addr_ok  = rx_data[7:5] == 3'b000;
    assign at_max   = wait_cnt == WW'(MAX_WAIT);
    assign grant    = state == WRITE && (!wb_wr || at_max);
    assign busy     = state != IDLE;
    // Only high in the forced-grant cycle, when writeback is displaced.
    assign stall_o  = state == WRITE && wb_wr && at_max;

    always_ff @(posedge clk_o or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = addr_ok ? DATA : DISCARD;
            DATA:    if (accept && bcnt == 2'd3) state_nx = WRITE;
            DISCARD: if (accept && bcnt == 2'd3) state_nx = IDLE;
            WRITE:   if (grant) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frames addressed to x0 still complete and count, but never write.
    always_comb begin
        rf_wr    = grant ? addr != 5'd0 : wb_wr;
        rf_waddr = grant ? addr : wb_addr;
        rf_wdata = grant ? data : wb_data;
    end

    always_ff @(posedge clk_o or posedge rst) begin
        if (rst) begin
            bcnt       <= 2'd0;
            addr       <= 5'd0;
            data       <= 32'd0;
            wait_cnt   <= '0;
            load_count <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                case (state)
                    IDLE: begin
                        bcnt <= 2'd0;
                        if (addr_ok) addr <= rx_data[4:0];
                        else         err  <= 1'b1;
                    end
                    DATA: begin
                        data[{bcnt, 3'b000} +: 8] <= rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                    DISCARD: bcnt <= bcnt + 2'd1;
                    default: ;
                endcase
            end
            if (grant) begin
                load_count <= load_count + CNT_W'(1);
                wait_cnt   <= '0;
            end else if (state == WRITE && !at_max) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_load_arbiter.sv
// tb_regfile_load_arbiter: self-checking bench for regfile_load_arbiter
module tb_regfile_load_arbiter;
    logic        clk_o = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        wb_wr = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        stall_o, rf_wr, busy, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  load_count;

    int tests = 0;
    int fails = 0;
    int lowcnt = 0;
    logic [36:0] q[$];

    regfile_load_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk_o(clk_o), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_o(stall_o), .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .load_count(load_count), .err(err)
    );

    always #5 clk_o = ~clk_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: loader writes are popped and compared; writeback passthrough checked live.
    always @(negedge clk_o) begin
        if (!rst) begin
            if (!rx_ready) lowcnt++;
            if (wb_wr && !stall_o) begin
                chk("wb_pass", {rf_wr, rf_waddr, rf_wdata}, {1'b1, wb_addr, wb_data});
            end else if (rf_wr) begin
                if (q.size() == 0) chk("spurious_wr", {rf_waddr, rf_wdata}, 64'h0);
                else chk("loader_wr", {rf_waddr, rf_wdata}, q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk_o);
        while (!rx_ready && n < 40) begin
            @(negedge clk_o);
            n++;
        end
        if (!rx_ready) chk("rx_timeout", 64'd0, 64'd1);
        @(posedge clk_o);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
        if (a[7:5] == 3'b000 && a[4:0] != 5'd0) q.push_back({a[4:0], d});
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk("rst_busy", busy, 1'b0);
        chk("rst_state", {rx_ready, stall_o, load_count, err}, {1'b1, 1'b0, 8'd0, 1'b0});
        @(posedge clk_o);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [7:0]  cnt;
        logic        e;
    } vec_t;

    vec_t vt[6];
    int   lc0;

    initial begin
        vt[0] = '{8'h05, 32'h12345678, 8'd1, 1'b0};
        vt[1] = '{8'h00, 32'hAAAA5555, 8'd2, 1'b0};
        vt[2] = '{8'h25, 32'h11111111, 8'd2, 1'b1};
        vt[3] = '{8'h1F, 32'hCAFEF00D, 8'd3, 1'b1};
        vt[4] = '{8'hE0, 32'h00000000, 8'd3, 1'b1};
        vt[5] = '{8'h0A, 32'h87654321, 8'd4, 1'b1};

        #12;
        chk("reset_vals", {rx_ready, stall_o, rf_wr, busy, load_count, err},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
        @(posedge clk_o);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].a, vt[i].d);
            @(negedge clk_o);
            chk("grant_rf_wr", rf_wr, vt[i].a[7:5] == 3'b000 && vt[i].a[4:0] != 5'd0);
            @(posedge clk_o);
            #1;
            chk("tbl_count", load_count, vt[i].cnt);
            chk("tbl_err", err, vt[i].e);
            chk("tbl_busy", busy, 1'b0);
        end

        // Writeback holds the port for MAX_WAIT cycles, then a forced grant.
        wb_wr   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hDEADBEEF;
        send_frame(8'h05, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_o);
            chk("blocked_stall", {stall_o, rx_ready, rf_waddr}, {1'b0, 1'b0, 5'd3});
            @(posedge clk_o);
            #1;
        end
        @(negedge clk_o);
        chk("forced_stall", {stall_o, rf_wr, rf_waddr}, {1'b1, 1'b1, 5'd5});
        @(posedge clk_o);
        #1 wb_wr = 1'b0;
        chk("forced_count", load_count, 8'd5);
        chk("forced_busy", busy, 1'b0);

        // Reset mid-frame, then a clean frame to reg 7.
        send_byte(8'h09);
        chk("mid_busy", busy, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        send_frame(8'h07, 32'h77665544);
        @(posedge clk_o);
        #1 chk("after_rst_count", load_count, 8'd1);

        // 256 frames: count wraps, rx_ready low one cycle per frame.
        do_reset();
        lc0 = lowcnt;
        for (int i = 0; i < 256; i++) begin
            send_frame({3'b000, 5'($urandom_range(31, 1))}, $urandom);
            if (i == 254) begin
                @(posedge clk_o);
                #1 chk("count_255", load_count, 8'd255);
            end
        end
        @(posedge clk_o);
        #1;
        chk("count_wrap", load_count, 8'd0);
        chk("rx_low_cycles", lowcnt - lc0, 256);
        repeat (2) @(posedge clk_o);
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end
endmodule
